mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Consumer end of the EX->MEM pipeline interface: accepts ctrl_mem, rd_mem, alu_result,
//  write_data1 and pc4_mem, runs the data-memory access over a req/ack handshake,
//  and registers the write-back bundle for the WB stage.
//  Asserts mem_stall so EX and earlier stages hold while an access waits. Sits between EX and WB.
// PARAMETERS
//  TIMEOUT  16  max cycles dmem_req may stay high without dmem_ack before the access is aborted
// PORTS
//  clk          in   1   clock, all flops on posedge
//  reset_n      in   1   asynchronous reset, active low
//  ctrl_mem     in   5   [0] MemRead [1] MemWrite [2] RegWrite [4:3] WbSel (00 alu, 01 load, 10 pc4, 11 alu)
//  rd_mem       in   32  destination register; only [4:0] used
//  alu_result   in   32  memory address / ALU result
//  write_data1  in   32  store data
//  pc4_mem      in   32  PC+4 of the instruction
//  mem_stall    out  1   1 = upstream must hold its registers this edge
//  dmem_req     out  1   access request, held until ack or abort
//  dmem_we      out  1   1 = write, 0 = read; valid with dmem_req
//  dmem_addr    out  32  = alu_result while dmem_req
//  dmem_wdata   out  32  = write_data1 while dmem_req
//  dmem_ack     in   1   memory completes access this cycle; dmem_rdata valid on reads
//  dmem_rdata   in   32  load data
//  reg_write_wb out  1   registered RegWrite for WB
//  rd_wb        out  5   registered destination register
//  wb_data      out  32  registered write-back value selected by WbSel
//  mem_err      out  2   sticky: [0] misaligned access, [1] timeout; cleared only by reset
// BEHAVIOUR
//  - Reset (async, reset_n=0): FSM->IDLE, wait counter 0, reg_write_wb/rd_wb/wb_data/mem_err = 0.
//    dmem_req and mem_stall are forced 0 while reset_n=0.
//  - memop = ctrl_mem[0] | ctrl_mem[1]; both set is treated as a write.
//  - misaligned = memop & (alu_result[1:0] != 0): no request is issued; the instruction completes
//    this cycle. A load returns 0, a store is dropped, and mem_err[0] is set.
//  - FSM IDLE: memop & aligned -> dmem_req=1 combinationally.
//      ack same cycle: zero-wait completion, mem_stall=0, stay IDLE.
//      no ack: mem_stall=1, go to WAIT, counter=1.
//  - FSM WAIT: dmem_req=1 with inputs unchanged (upstream is stalled). Counter +1 per cycle.
//      ack: completion, mem_stall=0, go to IDLE.
//      counter==TIMEOUT without ack: abort, dmem_req=0 that cycle, mem_stall=0.
//        The instruction completes with load data 0, mem_err[1] is set, go to IDLE.
//  - mem_stall = dmem_req & ~dmem_ack & ~abort (combinational).
//  - WB register updates on every edge where mem_stall=0:
//      reg_write_wb <= ctrl_mem[2]; rd_wb <= rd_mem[4:0]
//      wb_data <= WbSel==01 ? load_data : WbSel==10 ? pc4_mem : alu_result
//    load_data = dmem_rdata on ack, 0 on abort or misalign.
//  - While mem_stall=1, the WB register loads a bubble: reg_write_wb <= 0; rd_wb and wb_data hold.
//  - ctrl_mem == 0 is a bubble: it passes through in one cycle with no request.
//  - dmem_ack while dmem_req=0 is ignored.
//  - Reset mid-WAIT: request dropped immediately, FSM->IDLE, no WB update.
//  - Latency: every instruction reaches the WB register at the first edge with mem_stall=0
//    (1 cycle for non-mem ops and zero-wait accesses).
// TESTING
//  - ALU op: ctrl=5'b00100, rd=5, alu=0x1234 -> after 1 edge reg_write_wb=1, rd_wb=5, wb_data=0x1234; dmem_req never 1.
//  - Load, ack 3 cycles late: ctrl=5'b01101, alu=0x100, rdata=0xDEADBEEF -> mem_stall=1 for 3 cycles,
//    then wb_data=0xDEADBEEF, reg_write_wb=1; reg_write_wb=0 during the stall.
//  - Zero-wait store: ctrl=5'b00010, alu=0x40, wdata=0x55, ack same cycle -> dmem_we=1, addr=0x40,
//    wdata=0x55, no stall, reg_write_wb=0.
//  - Timeout: load, ack never asserted, TIMEOUT=16 -> stall 16 cycles, then wb_data=0, mem_err=2'b10,
//    dmem_req drops.
//  - Misaligned load: alu=0x102 -> no dmem_req, wb_data=0, mem_err[0]=1, error persists until reset.
//  - Reset in WAIT: pull reset_n low mid-stall -> dmem_req=0, mem_stall=0 and all WB outputs 0 immediately.

Source files
------------

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module : mem_stage
// Brief  : MEM pipeline stage - data-memory req/ack access with stall, timeout
//          abort, misalignment trap and a registered write-back bundle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  ctrl_mem,
    input  logic [31:0] rd_mem,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data1,
    input  logic [31:0] pc4_mem,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        reg_write_wb,
    output logic [4:0]  rd_wb,
    output logic [31:0] wb_data,
    output logic [1:0]  mem_err
);

    localparam int              CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   C_TIMEOUT = CW'(TIMEOUT);
    localparam logic [0:0]      S_IDLE    = 1'b0;
    localparam logic [0:0]      S_WAIT    = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_memop;
    logic          w_misaligned;
    logic          w_abort;
    logic [31:0]   w_load_data;
    logic [31:0]   w_wb_data;

    logic          reg_write_wb_q;
    logic [4:0]    rd_wb_q;
    logic [31:0]   wb_data_q;
    logic [1:0]    mem_err_q, mem_err_d;

    // Upper destination-register bits are architecturally unused.
    logic          unused_rd_hi;
    assign unused_rd_hi = ^rd_mem[31:5];

    assign w_memop      = ctrl_mem[0] | ctrl_mem[1];
    assign w_misaligned = w_memop & (alu_result[1:0] != 2'b00);

    assign dmem_we      = ctrl_mem[1];
    assign dmem_addr    = alu_result;
    assign dmem_wdata   = write_data1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dmem_req && !dmem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            S_WAIT: begin
                if (w_abort || dmem_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs; reset forces the request and stall low even mid-access.
    always_comb begin
        dmem_req = 1'b0;
        w_abort  = 1'b0;
        case (state_q)
            S_IDLE:  dmem_req = w_memop & ~w_misaligned;
            S_WAIT: begin
                w_abort  = (cnt_q == C_TIMEOUT);
                dmem_req = ~w_abort;
            end
            default: dmem_req = 1'b0;
        endcase
        if (!reset_n) begin
            dmem_req = 1'b0;
            w_abort  = 1'b0;
        end
        mem_stall = dmem_req & ~dmem_ack & ~w_abort;
    end

    assign w_load_data = (dmem_req && dmem_ack) ? dmem_rdata : 32'h0;

    always_comb begin
        case (ctrl_mem[4:3])
            2'b01:   w_wb_data = w_load_data;
            2'b10:   w_wb_data = pc4_mem;
            default: w_wb_data = alu_result;
        endcase
    end

    assign mem_err_d = mem_err_q
                     | {w_abort, w_misaligned & (state_q == S_IDLE) & reset_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_wb_q <= 1'b0;
            rd_wb_q        <= 5'd0;
            wb_data_q      <= 32'h0;
            mem_err_q      <= 2'b00;
        end else begin
            mem_err_q <= mem_err_d;
            if (mem_stall) begin
                reg_write_wb_q <= 1'b0;
            end else begin
                reg_write_wb_q <= ctrl_mem[2];
                rd_wb_q        <= rd_mem[4:0];
                wb_data_q      <= w_wb_data;
            end
        end
    end

    assign reg_write_wb = reg_write_wb_q;
    assign rd_wb        = rd_wb_q;
    assign wb_data      = wb_data_q;
    assign mem_err      = mem_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module : tb_mem_stage
// Brief  : Directed scoreboard bench for mem_stage.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ctrl_mem;
    logic [31:0] rd_mem, alu_result, write_data1, pc4_mem;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        reg_write_wb;
    logic [4:0]  rd_wb;
    logic [31:0] wb_data;
    logic [1:0]  mem_err;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ctrl_mem     (ctrl_mem),
        .rd_mem       (rd_mem),
        .alu_result   (alu_result),
        .write_data1  (write_data1),
        .pc4_mem      (pc4_mem),
        .mem_stall    (mem_stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .reg_write_wb (reg_write_wb),
        .rd_wb        (rd_wb),
        .wb_data      (wb_data),
        .mem_err      (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one instruction (called at a negedge) and follow it until it retires.
    // ack_delay < 0 means the memory never acknowledges.
    task automatic run_instr(input string tag, input logic [4:0] ctrl, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                             input int ack_delay, input logic [31:0] rdata,
                             input int exp_stalls, input logic exp_req0, input logic exp_req_last,
                             input logic [31:0] exp_data);
        wb_t e;
        wb_t got;
        int  nstall = 0;
        bit  done   = 0;
        ctrl_mem    = ctrl;
        rd_mem      = {27'h0, rd};
        alu_result  = alu;
        write_data1 = wd;
        pc4_mem     = pc4;
        dmem_rdata  = rdata;
        e.rw   = ctrl[2];
        e.rd   = rd;
        e.data = exp_data;
        exp_q.push_back(e);
        for (int n = 0; n < 40 && !done; n++) begin
            dmem_ack = (n == ack_delay);
            #1;
            if (n == 0) chk({tag, ".req0"}, {31'h0, dmem_req}, {31'h0, exp_req0});
            if (!mem_stall) chk({tag, ".req_last"}, {31'h0, dmem_req}, {31'h0, exp_req_last});
            if (mem_stall) begin
                nstall++;
                @(posedge clk); #1;
                if (n == 0) chk({tag, ".bubble_rw"}, {31'h0, reg_write_wb}, 32'h0);
            end else begin
                @(posedge clk); #1;
                if (exp_q.size() == 0) begin
                    chk({tag, ".sb_empty"}, 32'h1, 32'h0);
                end else begin
                    got = exp_q.pop_front();
                    chk({tag, ".rw"},   {31'h0, reg_write_wb}, {31'h0, got.rw});
                    chk({tag, ".rd"},   {27'h0, rd_wb},        {27'h0, got.rd});
                    chk({tag, ".data"}, wb_data,               got.data);
                end
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk({tag, ".retire_timeout"}, 32'h1, 32'h0);
        chk({tag, ".stalls"}, nstall, exp_stalls);
        dmem_ack = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        ctrl_mem    = 5'd0;
        rd_mem      = 32'h0;
        alu_result  = 32'h0;
        write_data1 = 32'h0;
        pc4_mem     = 32'h0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.rw",    {31'h0, reg_write_wb}, 32'h0);
        chk("rst.data",  wb_data, 32'h0);
        chk("rst.err",   {30'h0, mem_err}, 32'h0);
        chk("rst.stall", {31'h0, mem_stall}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // ALU op: single-cycle, no request
        run_instr("alu", 5'b00100, 5'd5, 32'h1234, 32'h0, 32'h0, -1, 32'h0, 0, 1'b0, 1'b0, 32'h1234);
        // Load acked three cycles late
        run_instr("ld3", 5'b01101, 5'd7, 32'h100, 32'h0, 32'h0, 3, 32'hDEADBEEF, 3, 1'b1, 1'b1, 32'hDEADBEEF);

        // Zero-wait store: check request attributes on its single cycle
        ctrl_mem = 5'b00010; alu_result = 32'h40; write_data1 = 32'h55; dmem_ack = 1'b1;
        #1;
        chk("st.we",    {31'h0, dmem_we}, 32'h1);
        chk("st.addr",  dmem_addr, 32'h40);
        chk("st.wdata", dmem_wdata, 32'h55);
        run_instr("st", 5'b00010, 5'd0, 32'h40, 32'h55, 32'h0, 0, 32'h0, 0, 1'b1, 1'b1, 32'h40);

        // Bubble with a stray ack that must be ignored
        run_instr("bub", 5'b00000, 5'd3, 32'h77, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h77);
        // PC+4 write-back select
        run_instr("jal", 5'b10100, 5'd1, 32'h999, 32'h0, 32'h2004, -1, 32'h0, 0, 1'b0, 1'b0, 32'h2004);
        // WbSel=11 falls back to the ALU result
        run_instr("sel3", 5'b11100, 5'd9, 32'hABC, 32'h0, 32'h2008, -1, 32'h0, 0, 1'b0, 1'b0, 32'hABC);

        // Timeout: never acked
        run_instr("tmo", 5'b01101, 5'd8, 32'h200, 32'h0, 32'h0, -1, 32'h1111_1111, 16, 1'b1, 1'b0, 32'h0);
        chk("tmo.err", {30'h0, mem_err}, 32'h2);

        // Misaligned load
        run_instr("mis", 5'b01101, 5'd4, 32'h102, 32'h0, 32'h0, 0, 32'h2222_2222, 0, 1'b0, 1'b0, 32'h0);
        chk("mis.err", {30'h0, mem_err}, 32'h3);
        run_instr("alu2", 5'b00100, 5'd6, 32'h5678, 32'h0, 32'h0, -1, 32'h0, 0, 1'b0, 1'b0, 32'h5678);
        chk("err.sticky", {30'h0, mem_err}, 32'h3);

        // Reset while waiting on an access
        ctrl_mem = 5'b01101; rd_mem = 32'd2; alu_result = 32'h300; dmem_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("wait.stall", {31'h0, mem_stall}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstw.req",   {31'h0, dmem_req}, 32'h0);
        chk("rstw.stall", {31'h0, mem_stall}, 32'h0);
        chk("rstw.rw",    {31'h0, reg_write_wb}, 32'h0);
        chk("rstw.rd",    {27'h0, rd_wb}, 32'h0);
        chk("rstw.data",  wb_data, 32'h0);
        chk("rstw.err",   {30'h0, mem_err}, 32'h0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Back in IDLE: a zero-wait load completes normally
        run_instr("ld0", 5'b01101, 5'd11, 32'h44, 32'h0, 32'h0, 0, 32'hCAFE_F00D, 0, 1'b1, 1'b1, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
